// File: rtl/vlsu_pkg.sv
// Shared constants and FSM state type for the vector load/store unit.
// MEM_DEPTH is the size of the attached vector data memory in words; MAX_BASE
// is the highest base address whose 16-lane access stays inside the memory
// without wrapping.
package vlsu_pkg;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LANES     = 16;
  localparam int unsigned DATA_W    = LANES * WORD_W;
  localparam int unsigned VREG_W    = 2;
  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned MAX_BASE  = MEM_DEPTH - LANES;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StWb
  } state_e;

endpackage

// File: rtl/vector_lsu.sv
// Vector load/store unit in front of the 512 x 32-bit vector data memory.
// Takes one command at a time, drives the memory for a single ISSUE cycle and,
// for loads, captures the registered read data and returns it over a
// valid/ready writeback port.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   cmd_*              command handshake (cmd_ready high only when idle)
//   mem_*              memory interface (enables are high only in ISSUE)
//   wb_*               load result writeback, held until wb_ready
//   store_done         one-cycle pulse the cycle after a store's ISSUE
//   err                one-cycle pulse for a rejected command
//
// Build option: define VLSU_BOUNDS_CHECK_EN to reject any command whose base
// address would make the access wrap past the end of memory. Without it, err
// stays 0 and wrapping accesses are issued unchanged.
module vector_lsu
  import vlsu_pkg::*;
#(
  parameter int unsigned ADDR_W = vlsu_pkg::ADDR_W,
  parameter int unsigned WORD_W = vlsu_pkg::WORD_W,
  parameter int unsigned LANES  = vlsu_pkg::LANES,
  parameter int unsigned VREG_W = vlsu_pkg::VREG_W,
  localparam int unsigned DATA_W = LANES * WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_store,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [VREG_W-1:0] cmd_vreg,
  input  logic [DATA_W-1:0] cmd_store_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [VREG_W-1:0] wb_vreg,
  output logic [DATA_W-1:0] wb_data,
  output logic              store_done,
  output logic              err
);

  state_e              state;
  logic                is_store_q;
  logic [VREG_W-1:0]   vreg_q;
  logic                reject;

`ifdef VLSU_BOUNDS_CHECK_EN
  localparam int unsigned MaxBase = MEM_DEPTH - LANES;
  assign reject = 32'(cmd_addr) > MaxBase;
`else
  assign reject = 1'b0;
`endif

  assign cmd_ready = (state == StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      is_store_q     <= 1'b0;
      vreg_q         <= '0;
      mem_write_en   <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      wb_valid       <= 1'b0;
      wb_vreg        <= '0;
      wb_data        <= '0;
      store_done     <= 1'b0;
      err            <= 1'b0;
    end else begin
      // Pulses and enables default low; each is raised for exactly one cycle.
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      store_done   <= 1'b0;
      err          <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd_valid && reject) begin
            // Accepted but dropped: no memory access, stay idle.
            err <= 1'b1;
          end else if (cmd_valid) begin
            // Address and data are captured straight into the memory-facing
            // registers so they are already valid during ISSUE.
            is_store_q     <= cmd_is_store;
            vreg_q         <= cmd_vreg;
            mem_address    <= cmd_addr;
            mem_write_data <= cmd_store_data;
            mem_write_en   <= cmd_is_store;
            mem_read_en    <= !cmd_is_store;
            state          <= StIssue;
          end
        end
        StIssue: begin
          store_done <= is_store_q;
          state      <= is_store_q ? StIdle : StCapture;
        end
        StCapture: begin
          // Memory read data is valid the cycle after read_en.
          wb_data  <= mem_read_data;
          wb_vreg  <= vreg_q;
          wb_valid <= 1'b1;
          state    <= StWb;
        end
        StWb: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/vector_lsu.md
Name: vector_lsu

Overview:
Vector load/store unit sitting directly upstream of the 512 x 32-bit vector data memory. Accepts one load or store command at a time from the decode/execute stage and drives the memory's write_en/read_en/address/write_data. For loads, it captures the memory's registered 512-bit read_data and returns it to the vector register file over a valid/ready writeback port.

Parameters:
ADDR_W, 9, word address width (memory depth 512)
WORD_W, 32, bits per memory word
LANES, 16, words per vector access; DATA_W = LANES*WORD_W = 512 (derived localparam)
VREG_W, 2, vector register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  unit idle, can accept a command
cmd_is_store  in  1  1 = store, 0 = load
cmd_addr  in  ADDR_W  base word address
cmd_vreg  in  VREG_W  destination register (loads)
cmd_store_data  in  DATA_W  store payload; lane i goes to word addr+i
mem_write_en  out  1  to memory write_en
mem_read_en  out  1  to memory read_en
mem_address  out  ADDR_W  to memory address
mem_write_data  out  DATA_W  to memory write_data
mem_read_data  in  DATA_W  from memory read_data (valid cycle after read_en)
wb_valid  out  1  load result available
wb_ready  in  1  register file accepts result
wb_vreg  out  VREG_W  destination register of result
wb_data  out  DATA_W  load result
store_done  out  1  one-cycle pulse, store committed
err  out  1  one-cycle pulse, command rejected (see Optional Feature)

Behaviour:
- Reset (sync, active-high, clk): state IDLE; cmd_ready=1 from the cycle after reset. All other outputs 0: mem_write_en, mem_read_en, mem_address, mem_write_data, wb_valid, wb_vreg, wb_data, store_done, err.
- FSM states: IDLE, ISSUE, CAPTURE, WB.
- IDLE: cmd_ready=1. On cmd_valid, latch is_store/addr/vreg/store_data and go to ISSUE.
- ISSUE (1 cycle): cmd_ready=0. mem_address=latched addr. mem_write_en=is_store, mem_read_en=!is_store. mem_write_data=latched data. Never assert both enables.
  - Store: go to IDLE; store_done=1 in the following cycle.
  - Load: go to CAPTURE.
- CAPTURE (1 cycle): register mem_read_data into wb_data and latched vreg into wb_vreg; go to WB.
- WB: wb_valid=1; wb_data and wb_vreg held stable until wb_ready. On wb_ready, go to IDLE with wb_valid=0 next cycle. wb_ready while wb_valid=0 is ignored.
- Latency:
  - Load: accept edge to wb_valid high = 3 cycles.
  - Store: accept to store_done = 2 cycles.
  - Throughput: one store per 2 cycles; a new command may be accepted in the cycle store_done is high.
- Memory enables are 0 in every state except ISSUE. mem_address/mem_write_data retain their last value when idle.
- Wrap-around: addresses are passed unchanged; the memory wraps lanes mod 512. Base 500 touches words 500..511, 0..3.
- Reset mid-operation: any state returns to IDLE. The pending command is dropped; no wb_valid, store_done, or memory enable is produced.

Optional Feature:
VLSU_BOUNDS_CHECK_EN.
- Defined: a command with addr > 512-LANES (496) is accepted in IDLE, produces no ISSUE (no memory enable), and pulses err=1 in the next cycle. The unit returns to IDLE.
- Undefined: err is tied 0 and wrapping accesses issue normally.

Decomposition:
- Package vlsu_pkg: state enum (IDLE/ISSUE/CAPTURE/WB), ADDR_W/WORD_W/LANES/DATA_W constants, MEM_DEPTH=512, MAX_BASE=MEM_DEPTH-LANES.
- Single module; no sub-module is warranted, as the FSM and holding registers are tightly coupled.

Test Plan:
- Store at addr 20 with lane i = 32'hA000_0000+i, then load addr 20 into vreg 1 → store_done 2 cycles after accept; wb_valid 3 cycles after load accept; wb_data lanes = A000_0000..A000_000F; wb_vreg=1.
- Load base 500 after storing lanes i=i at base 500 → wb_data lanes 0..15 = 0..15 (words 500..511, 0..3). With VLSU_BOUNDS_CHECK_EN: err pulse, mem_read_en never high.
- Hold wb_ready=0 for 5 cycles during a load → wb_valid and wb_data stable for all 5 cycles, cmd_ready=0; release → IDLE next cycle.
- Back-to-back stores with cmd_valid held high → accepts every 2 cycles; mem_write_en pattern 0,1,0,1; mem_read_en always 0.
- Assert reset in the CAPTURE state of a load → all outputs 0 next cycle, cmd_ready=1 after; no wb_valid ever appears.
- After reset, load addr 0 → wb_data word 2 = FFFF_FFFF, word 8 = 8000_0000 (memory reset contents).
